// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder (optional subtract via SERIAL_ADDER_SUB_EN)
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             s;
  logic             c_next;
  logic             sub_in;

`ifdef SERIAL_ADDER_SUB_EN
  assign sub_in = sub;
`else
  assign sub_in = 1'b0;
`endif

  // single full-adder cell on the current LSBs
  assign s      = a_sh[0] ^ b_sh[0] ^ carry;
  assign c_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);

  // control FSM plus datapath shift registers, one bit per ADD cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            a_sh  <= a;
            // subtract = add inverted b with carry-in preset to 1
            b_sh  <= b ^ {WIDTH{sub_in}};
            carry <= sub_in;
            cnt   <= '0;
            sum   <= '0;
            busy  <= 1'b1;
            state <= ADD;
          end
        end
        ADD: begin
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          carry <= c_next;
          sum   <= {s, sum[WIDTH-1:1]};
          if (cnt == LAST) begin
            // last bit: keep cnt in range and publish the final carry
            cnt   <= '0;
            cout  <= c_next;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder
module tb_serial_adder;

  parameter int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int  n_assert;
  int  n_fail;
  time last_done;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [W-1:0] ny;
    ny = ~y;
    if (s) return (W+1)'(x) + (W+1)'(ny) + (W+1)'(1);
    return (W+1)'(x) + (W+1)'(y);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called at a negedge while IDLE; returns at the negedge of the first IDLE cycle after done
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_b, input logic ts,
                       input int poke, input string tag);
    logic [W:0] exp;
    int n;
    exp = model(ta, tb_b, ts);
    a = ta; b = tb_b; sub = ts; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    n = 0;
    while (!done && n < W + 4) begin
      check({tag, " busy_in_add"}, 64'(busy), 64'(1));
      if (n == poke) begin
        start = 1'b1; a = W'(8'hAA); b = W'(8'h55);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    last_done = $time;
    check({tag, " latency"}, 64'(n), 64'(W));
    check({tag, " done"}, 64'(done), 64'(1));
    check({tag, " busy_done"}, 64'(busy), 64'(1));
    check({tag, " sum"}, 64'(sum), 64'(exp[W-1:0]));
    check({tag, " cout"}, 64'(cout), 64'(exp[W]));
    @(negedge clk);
    check({tag, " done_pulse"}, 64'(done), 64'(0));
    check({tag, " busy_idle"}, 64'(busy), 64'(0));
    check({tag, " sum_hold"}, 64'(sum), 64'(exp[W-1:0]));
    check({tag, " cout_hold"}, 64'(cout), 64'(exp[W]));
  endtask

  initial begin
    logic [W-1:0] ones;
    time prev;
    n_assert = 0;
    n_fail   = 0;
    ones     = '1;
    rst_n = 1'b0; start = 1'b1; a = '1; b = '1; sub = 1'b0;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset sum", 64'(sum), 64'(0));
    check("reset cout", 64'(cout), 64'(0));
    rst_n = 1'b1; start = 1'b0;
    @(negedge clk);

    do_op(W'(8'h35), W'(8'h4A), 1'b0, -1, "basic");
    do_op(ones, W'(1), 1'b0, -1, "ones_plus_one");
    do_op(ones, ones, 1'b0, -1, "ones_plus_ones");
    do_op('0, '0, 1'b0, -1, "zero_plus_zero");
    do_op(W'(8'h10), W'(8'h20), 1'b0, 2, "ignored_start");

    // reset in the middle of an operation discards it
    a = W'(8'h0F); b = W'(1); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset busy", 64'(busy), 64'(0));
    check("midreset done", 64'(done), 64'(0));
    check("midreset sum", 64'(sum), 64'(0));
    check("midreset cout", 64'(cout), 64'(0));
    repeat (W + 2) begin
      @(negedge clk);
      check("midreset no_done", 64'(done), 64'(0));
    end
    do_op(W'(8'h0F), W'(1), 1'b0, -1, "after_reset");

    // back-to-back: restart in the IDLE cycle right after done
    do_op(W'($urandom), W'($urandom), 1'b0, -1, "b2b_first");
    prev = last_done;
    do_op(W'($urandom), W'($urandom), 1'b0, -1, "b2b_second");
    check("b2b spacing", 64'((last_done - prev) / 10), 64'(W + 2));

    for (int i = 0; i < 12; i++) begin
      do_op(W'($urandom), W'($urandom), 1'b0, -1, "random_add");
    end

`ifdef SERIAL_ADDER_SUB_EN
    do_op(W'(5), W'(3), 1'b1, -1, "sub_5_3");
    do_op(W'(3), W'(5), 1'b1, -1, "sub_3_5");
    do_op(W'(7), W'(7), 1'b1, -1, "sub_equal");
    for (int i = 0; i < 8; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), -1, "random_mixed");
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
